// File: rtl/tiny_risc_v_pkg.sv
// Shared constants and types for the tiny_risc_v memory sequencer.
package tiny_risc_v_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  // Requester IDs; also used as bit positions in the request/grant vectors
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Latency counter width; holds RD_LAT values 1..3
  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } arb_state_t;

endpackage

// File: rtl/tiny_mem_arbiter_if.sv
// Requester and RAM-side signal bundle for tiny_mem_arbiter.
interface tiny_mem_arbiter_if
  import tiny_risc_v_pkg::*;
  ();

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // RAM pins
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, q,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output address, data, wren
  );

  // Core + RAM side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, q,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  address, data, wren
  );

endinterface

// File: rtl/tiny_mem_arbiter_rr_arb2.sv
// Two-request round-robin picker; owns the last-granted pointer.
module rr_arb2
  import tiny_risc_v_pkg::*;
(
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // Pick a winner when allowed to advance; on a tie the port not granted last wins
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (adv) begin
      if (req == 2'b11) begin
        if (last_q == PORT_IF) gnt[PORT_D] = 1'b1;
        else                   gnt[PORT_IF] = 1'b1;
      end else begin
        gnt = req;
      end
    end
    if (gnt[PORT_D])       last_d = PORT_D;
    else if (gnt[PORT_IF]) last_d = PORT_IF;
  end

  // Pointer register; reset favours data on the first tie
  always_ff @(posedge clock) begin
    if (rst) last_q <= PORT_IF;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/tiny_mem_arbiter.sv
// Shares one single-port synchronous RAM between a fetch port and a data port.
module tiny_mem_arbiter
  import tiny_risc_v_pkg::*;
#(
  parameter int unsigned ADDR_W = tiny_risc_v_pkg::ADDR_W,
  parameter int unsigned DATA_W = tiny_risc_v_pkg::DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clock,
  input  logic               rst,
  tiny_mem_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              adv;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c;
  logic              wren_c;

  assign req = {bus.d_req, bus.if_req};
  assign adv = (state_q == IDLE);

  rr_arb2 u_arb (
    .clock (clock),
    .rst   (rst),
    .req   (req),
    .adv   (adv),
    .gnt   (gnt)
  );

  // Next state, RAM muxing and read-data capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    addr_c      = '0;
    data_c      = '0;
    wren_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt[PORT_D]) begin
          addr_c = bus.d_addr;
          data_c = bus.d_wdata;
          if (bus.d_we) begin
            wren_c = 1'b1;
          end else begin
            state_d = RD_WAIT;
            owner_d = PORT_D;
            cnt_d   = CNT_W'(RD_LAT);
          end
        end else if (gnt[PORT_IF]) begin
          addr_c  = bus.if_addr;
          state_d = RD_WAIT;
          owner_d = PORT_IF;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // q is valid in the cycle the counter reads 1
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (owner_q == PORT_D) begin
            d_rdata_d  = bus.q;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = bus.q;
            if_rvalid_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State, counter, owner and read-data registers
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= PORT_IF;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_gnt    = gnt[PORT_IF];
  assign bus.d_gnt     = gnt[PORT_D];
  assign bus.address   = addr_c;
  assign bus.data      = data_c;
  assign bus.wren      = wren_c;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_tiny_mem_arbiter.sv
// Directed bench for tiny_mem_arbiter: RD_LAT=1 instance (a) and RD_LAT=3 instance (b).
module tb_tiny_mem_arbiter;
  import tiny_risc_v_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic exp_last;
  logic win;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t sb_a[$];
  sb_t sb_b[$];

  tiny_mem_arbiter_if bus_a ();
  tiny_mem_arbiter_if bus_b ();

  tiny_mem_arbiter #(.RD_LAT(1)) dut_a (.clock(clock), .rst(rst), .bus(bus_a));
  tiny_mem_arbiter #(.RD_LAT(3)) dut_b (.clock(clock), .rst(rst), .bus(bus_b));

  always #5 clock = ~clock;

  // RAM models: a has one cycle of read latency, b has three
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] qa, pb0, pb1, pb2;

  always @(posedge clock) begin
    if (bus_a.wren) mem_a[bus_a.address] <= bus_a.data;
    qa <= mem_a[bus_a.address];
    if (bus_b.wren) mem_b[bus_b.address] <= bus_b.data;
    pb0 <= mem_b[bus_b.address];
    pb1 <= pb0;
    pb2 <= pb1;
  end

  assign bus_a.q = qa;
  assign bus_b.q = pb2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic ir, input logic [7:0] ia, input logic dr, input logic dwe,
                       input logic [7:0] da, input logic [31:0] dd);
    bus_a.if_req = ir; bus_a.if_addr = ia;
    bus_a.d_req = dr; bus_a.d_we = dwe; bus_a.d_addr = da; bus_a.d_wdata = dd;
  endtask

  task automatic drv_b(input logic ir, input logic [7:0] ia, input logic dr, input logic dwe,
                       input logic [7:0] da, input logic [31:0] dd);
    bus_b.if_req = ir; bus_b.if_addr = ia;
    bus_b.d_req = dr; bus_b.d_we = dwe; bus_b.d_addr = da; bus_b.d_wdata = dd;
  endtask

  // Expect a read return on instance inst, lat+1 cycles after the current (grant) cycle
  task automatic push(input int inst, input logic port, input logic [31:0] data, input int lat);
    sb_t e;
    e.port = port; e.data = data; e.due = cyc + lat + 1;
    if (inst == 0) sb_a.push_back(e);
    else           sb_b.push_back(e);
  endtask

  // Compare both instances' rvalid/rdata against the scoreboard heads
  task automatic check_rv();
    logic ei, ed;
    ei = 1'b0; ed = 1'b0;
    if (sb_a.size() > 0) begin
      if (sb_a[0].due == cyc) begin
        ei = (sb_a[0].port == PORT_IF);
        ed = (sb_a[0].port == PORT_D);
      end
    end
    chk("a.if_rvalid", 32'(bus_a.if_rvalid), 32'(ei));
    chk("a.d_rvalid", 32'(bus_a.d_rvalid), 32'(ed));
    if (ei) chk("a.if_rdata", bus_a.if_rdata, sb_a[0].data);
    if (ed) chk("a.d_rdata", bus_a.d_rdata, sb_a[0].data);
    if (ei || ed) void'(sb_a.pop_front());
    ei = 1'b0; ed = 1'b0;
    if (sb_b.size() > 0) begin
      if (sb_b[0].due == cyc) begin
        ei = (sb_b[0].port == PORT_IF);
        ed = (sb_b[0].port == PORT_D);
      end
    end
    chk("b.if_rvalid", 32'(bus_b.if_rvalid), 32'(ei));
    chk("b.d_rvalid", 32'(bus_b.d_rvalid), 32'(ed));
    if (ei) chk("b.if_rdata", bus_b.if_rdata, sb_b[0].data);
    if (ed) chk("b.d_rdata", bus_b.d_rdata, sb_b[0].data);
    if (ei || ed) void'(sb_b.pop_front());
  endtask

  // Check one instance's grant/RAM outputs for this cycle, check returns, then advance
  task automatic step(input int inst, input logic e_ig, input logic e_dg, input logic e_wr,
                      input logic [7:0] e_ad, input logic [31:0] e_dt, input bit chk_ad,
                      input string tag);
    #1;
    if (inst == 0) begin
      chk({tag, ".if_gnt"}, 32'(bus_a.if_gnt), 32'(e_ig));
      chk({tag, ".d_gnt"}, 32'(bus_a.d_gnt), 32'(e_dg));
      chk({tag, ".wren"}, 32'(bus_a.wren), 32'(e_wr));
      if (chk_ad) begin
        chk({tag, ".address"}, 32'(bus_a.address), 32'(e_ad));
        chk({tag, ".data"}, bus_a.data, e_dt);
      end
    end else begin
      chk({tag, ".if_gnt"}, 32'(bus_b.if_gnt), 32'(e_ig));
      chk({tag, ".d_gnt"}, 32'(bus_b.d_gnt), 32'(e_dg));
      chk({tag, ".wren"}, 32'(bus_b.wren), 32'(e_wr));
      if (chk_ad) begin
        chk({tag, ".address"}, 32'(bus_b.address), 32'(e_ad));
        chk({tag, ".data"}, bus_b.data, e_dt);
      end
    end
    check_rv();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  initial begin
    drv_a(0, 0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    exp_last = PORT_IF;

    // Reset state
    chk("rst.a.if_rdata", bus_a.if_rdata, 32'h0);
    chk("rst.a.d_rdata", bus_a.d_rdata, 32'h0);
    chk("rst.b.d_rdata", bus_b.d_rdata, 32'h0);
    step(0, 0, 0, 0, 8'h00, 32'h0, 1, "rst.a");

    // Write then fetch-read of the same address
    drv_a(0, 0, 1, 1, 8'h10, 32'hDEADBEEF);
    step(0, 0, 1, 1, 8'h10, 32'hDEADBEEF, 1, "wr10");
    drv_a(1, 8'h10, 0, 0, 0, 0);
    push(0, PORT_IF, 32'hDEADBEEF, 1);
    step(0, 1, 0, 0, 8'h10, 32'h0, 1, "rd10");
    drv_a(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 8'h00, 32'h0, 0, "rd10.wait");

    // Four back-to-back data writes, then readback
    for (int i = 0; i < 4; i++) begin
      drv_a(0, 0, 1, 1, 8'(i), 32'(i + 1));
      step(0, 0, 1, 1, 8'(i), 32'(i + 1), 1, "wr4");
    end
    drv_a(0, 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      push(0, PORT_D, 32'(i + 1), 1);
      step(0, 0, 1, 0, 8'(i), 32'h0, 1, "rb4");
      if (i < 3) drv_a(0, 0, 1, 0, 8'(i + 1), 0);
      else       drv_a(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 8'h00, 32'h0, 0, "rb4.wait");
    end

    // Fetch request arriving during RD_WAIT is held off until the return cycle
    drv_a(0, 0, 1, 0, 8'h01, 0);
    push(0, PORT_D, 32'h2, 1);
    step(0, 0, 1, 0, 8'h01, 32'h0, 1, "rdw.d");
    drv_a(1, 8'h03, 0, 0, 0, 0);
    step(0, 0, 0, 0, 8'h00, 32'h0, 0, "rdw.hold");
    push(0, PORT_IF, 32'h4, 1);
    step(0, 1, 0, 0, 8'h03, 32'h0, 1, "rdw.if");
    drv_a(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 8'h00, 32'h0, 0, "rdw.wait");

    // Reset one cycle after a read grant abandons the read
    drv_a(0, 0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 0, 8'h00, 32'h0, 1, "abort.gnt");
    drv_a(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 8'h00, 32'h0, 0, "abort.rst");
    rst = 1'b0;
    exp_last = PORT_IF;
    for (int i = 0; i < 3; i++) begin
      chk("abort.if_rdata", bus_a.if_rdata, 32'h0);
      chk("abort.d_rdata", bus_a.d_rdata, 32'h0);
      step(0, 0, 0, 0, 8'h00, 32'h0, 1, "abort.idle");
    end

    // Both ports hold reads: grants alternate starting with data
    drv_a(1, 8'h10, 1, 0, 8'h02, 0);
    for (int g = 0; g < 8; g++) begin
      win = (exp_last == PORT_IF) ? PORT_D : PORT_IF;
      if (win == PORT_D) begin
        push(0, PORT_D, 32'h3, 1);
        step(0, 0, 1, 0, 8'h02, 32'h0, 1, "alt.d");
      end else begin
        push(0, PORT_IF, 32'hDEADBEEF, 1);
        step(0, 1, 0, 0, 8'h10, 32'h0, 1, "alt.if");
      end
      exp_last = win;
      step(0, 0, 0, 0, 8'h00, 32'h0, 0, "alt.wait");
    end
    drv_a(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 8'h00, 32'h0, 1, "alt.end");

    // RD_LAT=3: write 8'h05, read it back, fetch held off for three wait cycles
    drv_b(0, 0, 1, 1, 8'h05, 32'h0000_00A5);
    step(1, 0, 1, 1, 8'h05, 32'h0000_00A5, 1, "l3.wr");
    drv_b(0, 0, 1, 0, 8'h05, 0);
    push(1, PORT_D, 32'h0000_00A5, 3);
    step(1, 0, 1, 0, 8'h05, 32'h0, 1, "l3.rd");
    drv_b(1, 8'h05, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h00, 32'h0, 0, "l3.wait");
    push(1, PORT_IF, 32'h0000_00A5, 3);
    step(1, 1, 0, 0, 8'h05, 32'h0, 1, "l3.if");
    drv_b(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'h00, 32'h0, 0, "l3.drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
